// File: rtl/sub_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sub_pkg : shared types and constants for nibble_serial_subtractor     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SLICE_W = 4;

  function automatic int num_slices(input int width);
    return width / SLICE_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cla4_slice.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cla4_slice : combinational 4-bit carry-lookahead adder cell           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [3:0] w_c;

  assign w_g = x & y;
  assign w_p = x ^ y;

  // Each carry is expanded directly from ci so no term ripples through another.
  assign w_c[0] = ci;
  assign w_c[1] = w_g[0] | (w_p[0] & ci);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign co     = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s = w_p ^ w_c;

endmodule
`default_nettype wire

// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | nibble_serial_subtractor : diff = a - b - bin, one nibble per clock   |
// | Optional signed overflow output enabled by SUB_SIGNED_OVF_EN.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module nibble_serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = num_slices(WIDTH);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
`ifdef SUB_SIGNED_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [SLICE_W-1:0] w_x;
  logic [SLICE_W-1:0] w_y;
  logic [SLICE_W-1:0] w_s;
  logic               w_co;

  // Subtraction as a + ~b + c, with the running carry the inverse of the borrow.
  assign w_x = a_q[{idx_q, 2'b00} +: SLICE_W];
  assign w_y = ~b_q[{idx_q, 2'b00} +: SLICE_W];

  cla4_slice u_cla4_slice (
    .x  (w_x),
    .y  (w_y),
    .ci (carry_q),
    .s  (w_s),
    .co (w_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SUB_SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = ~bin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        diff_d[{idx_q, 2'b00} +: SLICE_W] = w_s;
        carry_d = w_co;
        bout_d  = ~w_co;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
`ifdef SUB_SIGNED_OVF_EN
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (w_s[SLICE_W-1] != a_q[WIDTH-1]);
`endif
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SUB_SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SUB_SIGNED_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_nibble_serial_subtractor : scoreboard bench, WIDTH=16              |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_nibble_serial_subtractor;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] diff;
  logic        bout;
`ifdef SUB_SIGNED_OVF_EN
  logic        ovf;
`endif

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SUB_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("diff", {16'd0, diff}, {16'd0, e.d});
        chk("bout", {31'd0, bout}, {31'd0, e.bo});
`ifdef SUB_SIGNED_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
      end
    end
  end

  // Drives one operation and checks the done/busy cycle timing.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                        input logic [15:0] ed, input logic ebo, input logic eov,
                        input bit inject);
    sb_q.push_back('{d: ed, bo: ebo, ov: eov});
    a = ta; b = tb_; bin = tbin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_E0", {31'd0, busy}, 32'd1);
    chk("done_E0", {31'd0, done}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      if (inject && k == 1) begin
        start = 1'b1; a = 16'h0F0F;
      end
      @(posedge clk); #1;
      if (inject && k == 1) begin
        start = 1'b0; a = ta;
      end
      chk($sformatf("done_E%0d", k), {31'd0, done}, (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("busy_E%0d", k), {31'd0, busy}, 32'd1);
    end
    @(posedge clk); #1;
    chk("done_E5", {31'd0, done}, 32'd0);
    chk("busy_E5", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SUB_SIGNED_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif

    run_op(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b1);

    // Abort an operation with reset sampled at E2.
    a = 16'hABCD; b = 16'h1111; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_diff", {16'd0, diff}, 32'd0);
    done_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    chk("abort_no_done", done_seen, 32'd0);

    run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
